nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 162 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder built around a single 4-bit carry-lookahead
// cell. One nibble is added per clock, least-significant nibble first, and
// the carry between nibbles lives in a register. A full addition takes NIB
// (= WIDTH/4) clocks from the accepting edge, followed by a one-cycle done
// pulse during which the block is already idle again.
//
// WIDTH must be a multiple of 4 and at least 8.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request a new addition (only honoured while idle)
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry into nibble 0, captured on the accepting edge
//   busy   out  1      high while an addition is in progress
//   done   out  1      one-cycle pulse; sum/cout/ovf valid from this cycle on
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      carry out of the most significant nibble
//   ovf    out  1      two's-complement overflow of the signed interpretation

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] part;
  logic             carry;
  logic [KW-1:0]    k;
  logic             last;

  logic [3:0] cell_x;
  logic [3:0] cell_y;
  logic [3:0] cell_g;
  logic [3:0] cell_p;
  logic [4:0] cell_c;
  logic [3:0] cell_sum;
  logic       cell_cout;

  assign last = (k == KW'(NIB - 1));
  assign busy = (state == RUN);

  // 4-bit carry-lookahead cell. Every internal carry is written out as a
  // flat sum of generate/propagate products so the nibble carry chain is a
  // two-level function of the operands and the incoming carry register.
  always_comb begin
    cell_x    = a_reg[4*k +: 4];
    cell_y    = b_reg[4*k +: 4];
    cell_g    = cell_x & cell_y;
    cell_p    = cell_x ^ cell_y;
    cell_c[0] = carry;
    cell_c[1] = cell_g[0]
              | (cell_p[0] & carry);
    cell_c[2] = cell_g[1]
              | (cell_p[1] & cell_g[0])
              | (cell_p[1] & cell_p[0] & carry);
    cell_c[3] = cell_g[2]
              | (cell_p[2] & cell_g[1])
              | (cell_p[2] & cell_p[1] & cell_g[0])
              | (cell_p[2] & cell_p[1] & cell_p[0] & carry);
    cell_c[4] = cell_g[3]
              | (cell_p[3] & cell_g[2])
              | (cell_p[3] & cell_p[2] & cell_g[1])
              | (cell_p[3] & cell_p[2] & cell_p[1] & cell_g[0])
              | (cell_p[3] & cell_p[2] & cell_p[1] & cell_p[0] & carry);
    cell_sum  = cell_p ^ cell_c[3:0];
    cell_cout = cell_c[4];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start is only looked at while idle, so a request made
  // during RUN is simply dropped rather than queued.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN:  if (last)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath. Results are only written at the completion edge, so sum,
  // cout and ovf never expose a partially accumulated value. The top nibble
  // goes straight from the cell into sum instead of through part.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      part  <= '0;
      carry <= 1'b0;
      k     <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            k     <= '0;
            part  <= '0;
          end
        end
        RUN: begin
          part[4*k +: 4] <= cell_sum;
          carry          <= cell_cout;
          k              <= k + KW'(1);
          if (last) begin
            sum  <= {cell_sum, part[WIDTH-5:0]};
            cout <= cell_cout;
            ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (cell_sum[3] != a_reg[WIDTH-1]);
            done <= 1'b1;
            k    <= '0;
          end
        end
        default: begin
          k <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//
// Scoreboard bench for nibble_serial_adder (WIDTH=16). The driver issues
// additions and pushes the expected result, plus the cycle in which done
// should appear, onto a queue. An independent monitor pops that queue on
// every done pulse and compares; between pulses it checks that the
// registered result holds. Expected values come from plain integer
// arithmetic on the operands.

module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             cin   = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] hold_sum  = '0;
  logic             hold_cout = 1'b0;
  logic             hold_ovf  = 1'b0;
  bit               mon_en    = 1'b0;
  int               prev_done = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Reference: unsigned sum with carry-out, and signed overflow judged by
  // whether the true signed total leaves the representable range.
  function automatic exp_t refModel(input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    input logic ci);
    exp_t    e;
    longint  total;
    longint  stotal;
    longint  lim;
    total  = longint'(x) + longint'(y) + longint'(ci);
    stotal = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    lim    = longint'(1) << (WIDTH - 1);
    e.sum      = WIDTH'(total);
    e.cout     = (total >= (longint'(1) << WIDTH));
    e.ovf      = (stotal > lim - 1) || (stotal < -lim);
    e.done_cyc = 0;
    return e;
  endfunction

  // Called at a negedge while the DUT is idle (or in its done cycle).
  // Operands are scrambled right after the accepting edge to show they are
  // not sampled again.
  task automatic applyStimulus(input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y,
                               input logic ci);
    exp_t e;
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    e          = refModel(x, y, ci);
    e.done_cyc = cyc + NIB;
    exp_q.push_back(e);
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    cin   = 1'($urandom);
  endtask

  // Waits for done (bounded), counting busy cycles on the way. With disturb
  // set, operands and start are toggled during RUN. Returns at the negedge
  // of the done cycle with start low.
  task automatic waitDone(input bit disturb);
    int bc   = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 4 * NIB + 8 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) bc++;
        if (disturb) begin
          a     = WIDTH'($urandom);
          b     = WIDTH'($urandom);
          cin   = 1'($urandom);
          start = 1'($urandom);
        end
      end
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(seen), 32'd1);
    checkOutput("busy_cycles", bc, NIB);
  endtask

  // Monitor: consumes one scoreboard entry per done pulse and otherwise
  // checks that the last completed result is held.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        checkOutput("done_busy_exclusive", 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_entry", exp_q.size(), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("sum", 32'(sum), 32'(mon_e.sum));
          checkOutput("cout", 32'(cout), 32'(mon_e.cout));
          checkOutput("ovf", 32'(ovf), 32'(mon_e.ovf));
          checkOutput("done_cycle", cyc, mon_e.done_cyc);
          hold_sum  = mon_e.sum;
          hold_cout = mon_e.cout;
          hold_ovf  = mon_e.ovf;
        end
      end else begin
        checkOutput("result_hold", 32'({cout, ovf, sum}),
                    32'({hold_cout, hold_ovf, hold_sum}));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    rst_n  = 1'b0;
    mon_en = 1'b1;

    // Reset held with random activity on the inputs.
    repeat (6) begin
      @(negedge clk);
      checkOutput("reset_outputs", 32'({busy, done, cout, ovf, sum}), 32'd0);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom);
      start = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("idle_no_activity", 32'({busy, done}), 32'd0);
    end

    // Directed cases, issued back to back from each done cycle.
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    waitDone(1'b1);
    checkOutput("dir_1234_sum", 32'(sum), 32'h5555);
    checkOutput("dir_1234_cout_ovf", 32'({cout, ovf}), 32'd0);
    prev_done = cyc;

    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    waitDone(1'b0);
    checkOutput("done_spacing", cyc - prev_done, NIB + 1);
    checkOutput("dir_ffff_sum", 32'(sum), 32'h0000);
    checkOutput("dir_ffff_cout_ovf", 32'({cout, ovf}), 32'b10);
    prev_done = cyc;

    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    waitDone(1'b0);
    checkOutput("done_spacing", cyc - prev_done, NIB + 1);
    checkOutput("dir_7fff_sum", 32'(sum), 32'h8000);
    checkOutput("dir_7fff_cout_ovf", 32'({cout, ovf}), 32'b01);

    applyStimulus(16'h8000, 16'h8000, 1'b0);
    waitDone(1'b1);
    checkOutput("dir_8000_sum", 32'(sum), 32'h0000);
    checkOutput("dir_8000_cout_ovf", 32'({cout, ovf}), 32'b11);

    // Abort in the second RUN cycle.
    applyStimulus(16'hABCD, 16'h1357, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    hold_sum  = '0;
    hold_cout = 1'b0;
    hold_ovf  = 1'b0;
    #1;
    checkOutput("abort_outputs", 32'({busy, done, cout, ovf, sum}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus(16'h00FF, 16'h0001, 1'b0);
    waitDone(1'b0);
    checkOutput("post_abort_sum", 32'(sum), 32'h0100);
    checkOutput("post_abort_cout", 32'(cout), 32'd0);

    // Random traffic with occasional idle gaps and mid-run disturbance.
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      waitDone(1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
